// File: rtl/ins_ser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ins_ser_pkg
//  Description : Shared types, constants and helpers for the ins serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package ins_ser_pkg;

  // Shifter state: waiting for a word, or shifting one out
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Number of words that can wait behind the shifter
  localparam int BUF_DEPTH = 2;

  // Bit-index width; a 1-bit word still gets a 1-bit index
  function automatic int idx_w(input int width);
    return $clog2(width > 1 ? width : 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ins_ser_if.sv
`default_nettype none
// ============================================================================
//  Module      : ins_ser_if
//  Description : Parallel-in / serial-out handshake bundle for ins_serializer.
//                slave  = the serializer itself
//                master = the surrounding environment (word source + bit sink)
//  Revision    : 1.0 - initial release
// ============================================================================
interface ins_ser_if #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] ins;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_data;
  logic             ser_last;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    output in_valid, ins, ser_ready,
    input  in_ready, ser_valid, ser_data, ser_last, busy, frame_cnt
  );

  modport slave (
    input  in_valid, ins, ser_ready,
    output in_ready, ser_valid, ser_data, ser_last, busy, frame_cnt
  );
endinterface
`default_nettype wire

// File: rtl/ins_ser_buf.sv
`default_nettype none
// ============================================================================
//  Module      : ins_ser_buf
//  Description : Two-entry word FIFO sitting in front of the shifter.
//                Push while full and pop while empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module ins_ser_buf
  import ins_ser_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             push,
  input  wire logic             pop,
  input  wire logic [WIDTH-1:0] din,
  output logic      [WIDTH-1:0] dout,
  output logic      [1:0]       count,
  output logic                  full,
  output logic                  empty
);

  logic [WIDTH-1:0] r_mem [BUF_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == 2'(BUF_DEPTH));
  assign empty  = (r_count == 2'd0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign dout   = r_mem[r_rd_ptr];
  assign count  = r_count;

  // Pointer and occupancy tracking; simultaneous push/pop keeps count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Word storage; contents are only meaningful while counted
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/ins_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : ins_serializer
//  Description : Accepts WIDTH-bit "ins" words over valid/ready, buffers up
//                to two, and shifts each out one bit per accepted beat with
//                a last-bit marker and a completed-word counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module ins_serializer
  import ins_ser_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input wire logic clk,
  input wire logic rst_n,
  ins_ser_if.slave bus
);

  localparam int            IW       = idx_w(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_next_state;
  logic [WIDTH-1:0] r_shreg;
  logic [IW-1:0]    r_idx;
  logic [CNT_W-1:0] r_frame_cnt;

  logic             w_in_beat;
  logic             w_out_beat;
  logic             w_last;
  logic             w_ser_valid;
  logic             w_load;
  logic             w_load_buf;
  logic             w_push;
  logic             w_pop;
  logic             w_bit;
  logic [WIDTH-1:0] w_load_word;

  logic [WIDTH-1:0] w_buf_dout;
  logic [1:0]       w_buf_count;
  logic             w_buf_full;
  logic             w_buf_empty;

  ins_ser_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.ins),
    .dout  (w_buf_dout),
    .count (w_buf_count),
    .full  (w_buf_full),
    .empty (w_buf_empty)
  );

  // in_ready comes from registered occupancy only, never from ser_ready
  assign w_ser_valid = (r_state == SHIFT);
  assign w_in_beat   = bus.in_valid & ~w_buf_full;
  assign w_out_beat  = w_ser_valid & bus.ser_ready;
  assign w_last      = (r_idx == LAST_IDX);
  assign w_load_word = w_load_buf ? w_buf_dout : bus.ins;

  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign w_bit = r_shreg[r_idx];
    end else begin : g_msb_first
      assign w_bit = r_shreg[LAST_IDX - r_idx];
    end
  endgenerate

  // Next state and buffer/shifter steering; buffered words take priority over bypass
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_buf   = 1'b0;
    w_pop        = 1'b0;
    w_push       = w_in_beat;
    case (r_state)
      IDLE: begin
        if (!w_buf_empty) begin
          w_load       = 1'b1;
          w_load_buf   = 1'b1;
          w_pop        = 1'b1;
          w_next_state = SHIFT;
        end else if (w_in_beat) begin
          w_load       = 1'b1;
          w_push       = 1'b0;
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (w_out_beat && w_last) begin
          if (!w_buf_empty) begin
            w_load     = 1'b1;
            w_load_buf = 1'b1;
            w_pop      = 1'b1;
          end else if (w_in_beat) begin
            w_load = 1'b1;
            w_push = 1'b0;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Shifter word, bit index and completed-word counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg     <= '0;
      r_idx       <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_load) r_shreg <= w_load_word;
      if (w_load || (w_out_beat && w_last)) r_idx <= '0;
      else if (w_out_beat)                  r_idx <= r_idx + IW'(1);
      if (w_out_beat && w_last) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
    end
  end

  // Data/last are forced low while idle so reset and idle look identical
  assign bus.in_ready  = ~w_buf_full;
  assign bus.ser_valid = w_ser_valid;
  assign bus.ser_data  = w_ser_valid & w_bit;
  assign bus.ser_last  = w_ser_valid & w_last;
  assign bus.busy      = w_ser_valid | (w_buf_count != 2'd0);
  assign bus.frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ins_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ins_serializer
//  Description : Directed self-checking bench for ins_serializer.
//                u0: WIDTH=3 LSB first, u1: WIDTH=3 MSB first,
//                u2: WIDTH=3 CNT_W=2,    u3: WIDTH=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ins_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  ins_ser_if #(.WIDTH(3), .CNT_W(8)) if0 ();
  ins_ser_if #(.WIDTH(3), .CNT_W(8)) if1 ();
  ins_ser_if #(.WIDTH(3), .CNT_W(2)) if2 ();
  ins_ser_if #(.WIDTH(1), .CNT_W(8)) if3 ();

  ins_serializer #(.WIDTH(3), .LSB_FIRST(1'b1), .CNT_W(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  ins_serializer #(.WIDTH(3), .LSB_FIRST(1'b0), .CNT_W(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  ins_serializer #(.WIDTH(3), .LSB_FIRST(1'b1), .CNT_W(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  ins_serializer #(.WIDTH(1), .LSB_FIRST(1'b1), .CNT_W(8)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] w1;
    logic [8:0] s3;
    logic [2:0] w4;
    logic [2:0] w5;
    logic [1:0] fc6 [5];
    logic [3:0] p6;

    if0.in_valid = 1'b0; if0.ins = '0; if0.ser_ready = 1'b0;
    if1.in_valid = 1'b0; if1.ins = '0; if1.ser_ready = 1'b0;
    if2.in_valid = 1'b0; if2.ins = '0; if2.ser_ready = 1'b0;
    if3.in_valid = 1'b0; if3.ins = '0; if3.ser_ready = 1'b0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(if0.in_ready),  32'd1);
    chk("rst_ser_valid", 32'(if0.ser_valid), 32'd0);
    chk("rst_ser_data",  32'(if0.ser_data),  32'd0);
    chk("rst_ser_last",  32'(if0.ser_last),  32'd0);
    chk("rst_busy",      32'(if0.busy),      32'd0);
    chk("rst_frame_cnt", 32'(if0.frame_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // ---- single word 110, LSB first on u0 and MSB first on u1 ----
    w1 = 3'b110;
    if0.ser_ready = 1'b1; if1.ser_ready = 1'b1;
    if0.in_valid = 1'b1; if0.ins = w1;
    if1.in_valid = 1'b1; if1.ins = w1;
    tick();
    if0.in_valid = 1'b0; if1.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t1_valid", 32'(if0.ser_valid), 32'd1);
      chk("t1_data",  32'(if0.ser_data),  32'(w1[k]));
      chk("t1_last",  32'(if0.ser_last),  32'(k == 2));
      chk("t2_data",  32'(if1.ser_data),  32'(w1[2-k]));
      chk("t2_last",  32'(if1.ser_last),  32'(k == 2));
      tick();
    end
    chk("t1_frame",     32'(if0.frame_cnt), 32'd1);
    chk("t1_busy_done", 32'(if0.busy),      32'd0);
    chk("t1_idle",      32'(if0.ser_valid), 32'd0);
    chk("t2_frame",     32'(if1.frame_cnt), 32'd1);

    // ---- three back-to-back words 001, 010, 100 ----
    s3 = 9'b100_010_001;
    if0.in_valid = 1'b1; if0.ins = 3'b001;
    tick();
    for (int k = 0; k < 9; k++) begin
      chk("t3_valid", 32'(if0.ser_valid), 32'd1);
      chk("t3_data",  32'(if0.ser_data),  32'(s3[k]));
      chk("t3_last",  32'(if0.ser_last),  32'((k % 3) == 2));
      if (k == 0) if0.ins = 3'b010;
      if (k == 1) if0.ins = 3'b100;
      if (k == 2) begin
        chk("t3_in_ready_full", 32'(if0.in_ready), 32'd0);
        chk("t3_busy",          32'(if0.busy),     32'd1);
        if0.in_valid = 1'b0;
      end
      if (k == 3) chk("t3_in_ready_freed", 32'(if0.in_ready), 32'd1);
      tick();
    end
    chk("t3_frame", 32'(if0.frame_cnt), 32'd4);
    chk("t3_idle",  32'(if0.ser_valid), 32'd0);

    // ---- back-pressure: 101 stalled for 5 cycles after its first bit ----
    w4 = 3'b101;
    if0.in_valid = 1'b1; if0.ins = w4;
    tick();
    if0.in_valid = 1'b0;
    if0.ser_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_hold_valid", 32'(if0.ser_valid), 32'd1);
      chk("t4_hold_data",  32'(if0.ser_data),  32'd1);
      chk("t4_hold_last",  32'(if0.ser_last),  32'd0);
    end
    if0.ser_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("t4_data", 32'(if0.ser_data), 32'(w4[k]));
      chk("t4_last", 32'(if0.ser_last), 32'(k == 2));
      tick();
    end
    chk("t4_frame", 32'(if0.frame_cnt), 32'd5);

    // ---- reset mid-word with two words buffered ----
    w5 = 3'b011;
    if0.ser_ready = 1'b0;
    if0.in_valid = 1'b1; if0.ins = w5;
    tick();
    if0.ins = 3'b101;
    tick();
    if0.ins = 3'b110;
    tick();
    if0.in_valid = 1'b0;
    chk("t5_in_ready_full", 32'(if0.in_ready), 32'd0);
    if0.ser_ready = 1'b1;
    tick();
    chk("t5_second_bit", 32'(if0.ser_data), 32'(w5[1]));
    rst_n = 1'b0;
    #1;
    chk("t5_in_ready", 32'(if0.in_ready),  32'd1);
    chk("t5_valid",    32'(if0.ser_valid), 32'd0);
    chk("t5_data",     32'(if0.ser_data),  32'd0);
    chk("t5_last",     32'(if0.ser_last),  32'd0);
    chk("t5_busy",     32'(if0.busy),      32'd0);
    chk("t5_frame",    32'(if0.frame_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t5_no_emit", 32'(if0.ser_valid), 32'd0);
    end
    chk("t5_frame_after", 32'(if0.frame_cnt), 32'd0);

    // ---- CNT_W=2 wrap: frame_cnt 1,2,3,0,1 ----
    fc6[0] = 2'd1; fc6[1] = 2'd2; fc6[2] = 2'd3; fc6[3] = 2'd0; fc6[4] = 2'd1;
    if2.ser_ready = 1'b1;
    for (int w = 0; w < 5; w++) begin
      if2.in_valid = 1'b1; if2.ins = 3'(w + 1);
      tick();
      if2.in_valid = 1'b0;
      repeat (3) tick();
      chk("t6_wrap_frame", 32'(if2.frame_cnt), 32'(fc6[w]));
    end

    // ---- WIDTH=1: every bit is a last bit ----
    p6 = 4'b1101;
    if3.ser_ready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      if3.in_valid = 1'b1; if3.ins = p6[w];
      tick();
      if3.in_valid = 1'b0;
      chk("t6_w1_valid", 32'(if3.ser_valid), 32'd1);
      chk("t6_w1_last",  32'(if3.ser_last),  32'd1);
      chk("t6_w1_data",  32'(if3.ser_data),  32'(p6[w]));
      tick();
      chk("t6_w1_frame", 32'(if3.frame_cnt), 32'(w + 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
